// File: rtl/tl_buffer_pkg.sv
// Shared definitions for the TileLink-UL channel buffer: field widths, beat widths,
// packed beat layouts (opcode in the MSBs, corrupt in the LSB) and opcode encodings.
package tl_buffer_pkg;

  localparam int unsigned OpcodeW = 3;
  localparam int unsigned AParamW = 3;
  localparam int unsigned DParamW = 2;
  localparam int unsigned FlagW   = 1;

  // Default bus shape; the packed typedefs below use these.
  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefDataW = 64;
  localparam int unsigned DefSizeW = 3;
  localparam int unsigned DefSrcW  = 3;
  localparam int unsigned DefSinkW = 1;

  // A beat: opcode, param, size, source, address, mask, data, corrupt.
  function automatic int unsigned calc_a_w(input int unsigned addr_w, input int unsigned data_w,
                                           input int unsigned size_w, input int unsigned src_w);
    return OpcodeW + AParamW + size_w + src_w + addr_w + data_w / 8 + data_w + FlagW;
  endfunction

  // D beat: opcode, param, size, source, sink, denied, data, corrupt.
  function automatic int unsigned calc_d_w(input int unsigned data_w, input int unsigned size_w,
                                           input int unsigned src_w, input int unsigned sink_w);
    return OpcodeW + DParamW + size_w + src_w + sink_w + FlagW + data_w + FlagW;
  endfunction

  typedef struct packed {
    logic [OpcodeW-1:0]    opcode;
    logic [AParamW-1:0]    param;
    logic [DefSizeW-1:0]   size;
    logic [DefSrcW-1:0]    source;
    logic [DefAddrW-1:0]   address;
    logic [DefDataW/8-1:0] mask;
    logic [DefDataW-1:0]   data;
    logic                  corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [OpcodeW-1:0]  opcode;
    logic [DParamW-1:0]  param;
    logic [DefSizeW-1:0] size;
    logic [DefSrcW-1:0]  source;
    logic [DefSinkW-1:0] sink;
    logic                denied;
    logic [DefDataW-1:0] data;
    logic                corrupt;
  } tl_d_t;

  localparam logic [OpcodeW-1:0] OpPutFullData    = 3'd0;
  localparam logic [OpcodeW-1:0] OpPutPartialData = 3'd1;
  localparam logic [OpcodeW-1:0] OpGet            = 3'd4;
  localparam logic [OpcodeW-1:0] OpAccessAck      = 3'd0;
  localparam logic [OpcodeW-1:0] OpAccessAckData  = 3'd1;

endpackage

// File: rtl/tl_channel_buffer_if.sv
// TileLink-UL A/D channel bundle. The master modport drives A and accepts D;
// the slave modport accepts A and drives D.
interface tl_channel_buffer_if
  import tl_buffer_pkg::*;
#(
  parameter int unsigned A_W = calc_a_w(DefAddrW, DefDataW, DefSizeW, DefSrcW),
  parameter int unsigned D_W = calc_d_w(DefDataW, DefSizeW, DefSrcW, DefSinkW)
);
  logic           a_valid;
  logic           a_ready;
  logic [A_W-1:0] a_bits;
  logic           d_valid;
  logic           d_ready;
  logic [D_W-1:0] d_bits;

  modport master (output a_valid, a_bits, d_ready, input a_ready, d_valid, d_bits);
  modport slave  (input a_valid, a_bits, d_ready, output a_ready, d_valid, d_bits);
endinterface

// File: rtl/tl_buffer_fifo.sv
// Single-channel valid/ready FIFO with occupancy count. Payload is opaque.
// Optional flow-through path enabled by TL_CHANNEL_BUFFER_FLOW_EN.
module tl_buffer_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_bits_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_bits_o,
  output logic [CntW-1:0]  count_o
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push, pop, empty, full;
  logic [WIDTH-1:0] head;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign count_o = count_q;

  // Storage: written on push only, never reset.
  if (DEPTH == 1) begin : g_single
    assign head = mem_q[0];
    always_ff @(posedge clk_i) begin
      if (push) mem_q[0] <= in_bits_i;
    end
  end else begin : g_multi
    assign head = mem_q[rptr_q];
    always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= in_bits_i;
    end
  end

`ifdef TL_CHANNEL_BUFFER_FLOW_EN
  logic bypass;
  // An empty FIFO presents the incoming beat directly; if taken, it never touches storage.
  assign bypass      = empty && in_valid_i && out_ready_i;
  assign in_ready_o  = !full || out_ready_i;
  assign out_valid_o = !empty || in_valid_i;
  assign out_bits_o  = empty ? in_bits_i : head;
  assign push        = in_valid_i && in_ready_o && !bypass;
  assign pop         = !empty && out_ready_i;
`else
  assign in_ready_o  = !full;
  assign out_valid_o = !empty;
  assign out_bits_o  = head;
  assign push        = in_valid_i && !full;
  assign pop         = !empty && out_ready_i;
`endif

  // Next-state: pointers wrap at DEPTH-1, count tracks push minus pop.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = (wptr_q == PtrW'(DEPTH - 1)) ? '0 : wptr_q + PtrW'(1);
    if (pop)  rptr_d = (rptr_q == PtrW'(DEPTH - 1)) ? '0 : rptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the FIFO immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tl_channel_buffer.sv
// Two-channel TileLink-UL buffer: independent FIFOs on A (master->slave) and
// D (slave->master). Flow-through selected by TL_CHANNEL_BUFFER_FLOW_EN.
module tl_channel_buffer
  import tl_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned SIZE_W  = 3,
  parameter int unsigned SRC_W   = 3,
  parameter int unsigned SINK_W  = 1,
  parameter int unsigned A_DEPTH = 2,
  parameter int unsigned D_DEPTH = 2
) (
  input  logic                               clock,
  input  logic                               reset_n,
  tl_channel_buffer_if.slave                 mst,
  tl_channel_buffer_if.master                slv,
  output logic [$clog2(A_DEPTH + 1)-1:0]     a_count,
  output logic [$clog2(D_DEPTH + 1)-1:0]     d_count
);
  localparam int unsigned A_W = calc_a_w(ADDR_W, DATA_W, SIZE_W, SRC_W);
  localparam int unsigned D_W = calc_d_w(DATA_W, SIZE_W, SRC_W, SINK_W);

  tl_buffer_fifo #(
    .WIDTH (A_W),
    .DEPTH (A_DEPTH)
  ) u_a_fifo (
    .clk_i       (clock),
    .rst_ni      (reset_n),
    .in_valid_i  (mst.a_valid),
    .in_ready_o  (mst.a_ready),
    .in_bits_i   (mst.a_bits),
    .out_valid_o (slv.a_valid),
    .out_ready_i (slv.a_ready),
    .out_bits_o  (slv.a_bits),
    .count_o     (a_count)
  );

  tl_buffer_fifo #(
    .WIDTH (D_W),
    .DEPTH (D_DEPTH)
  ) u_d_fifo (
    .clk_i       (clock),
    .rst_ni      (reset_n),
    .in_valid_i  (slv.d_valid),
    .in_ready_o  (slv.d_ready),
    .in_bits_i   (slv.d_bits),
    .out_valid_o (mst.d_valid),
    .out_ready_i (mst.d_ready),
    .out_bits_o  (mst.d_bits),
    .count_o     (d_count)
  );

endmodule

// File: tb/tb_tl_channel_buffer.sv
// Bench for tl_channel_buffer: a default instance (depth 2/2) and a depth 3/1
// instance driven with random traffic against queue models.
module tb_tl_channel_buffer;
  import tl_buffer_pkg::*;

  localparam int unsigned AW = calc_a_w(DefAddrW, DefDataW, DefSizeW, DefSrcW);
  localparam int unsigned DW = calc_d_w(DefDataW, DefSizeW, DefSrcW, DefSinkW);
`ifdef TL_CHANNEL_BUFFER_FLOW_EN
  localparam bit FlowEn = 1'b1;
`else
  localparam bit FlowEn = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [1:0] a_count, a_count3;
  logic [1:0] d_count;
  logic [0:0] d_count3;

  tl_channel_buffer_if #(.A_W(AW), .D_W(DW)) mst_if ();
  tl_channel_buffer_if #(.A_W(AW), .D_W(DW)) slv_if ();
  tl_channel_buffer_if #(.A_W(AW), .D_W(DW)) mst3_if ();
  tl_channel_buffer_if #(.A_W(AW), .D_W(DW)) slv3_if ();

  tl_channel_buffer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .mst     (mst_if),
    .slv     (slv_if),
    .a_count (a_count),
    .d_count (d_count)
  );

  tl_channel_buffer #(.A_DEPTH(3), .D_DEPTH(1)) dut3 (
    .clock   (clock),
    .reset_n (reset_n),
    .mst     (mst3_if),
    .slv     (slv3_if),
    .a_count (a_count3),
    .d_count (d_count3)
  );

  always #5 clock = ~clock;

  function automatic logic [AW-1:0] rand_a();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[AW-1:0];
  endfunction

  function automatic logic [DW-1:0] rand_d();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    checks++; if (slv_if.a_valid !== 1'b0) begin failures++; $display("FAIL reset_out_a_valid got=%0b exp=0", slv_if.a_valid); end
    checks++; if (mst_if.d_valid !== 1'b0) begin failures++; $display("FAIL reset_out_d_valid got=%0b exp=0", mst_if.d_valid); end
    checks++; if (mst_if.a_ready !== 1'b1) begin failures++; $display("FAIL reset_in_a_ready got=%0b exp=1", mst_if.a_ready); end
    checks++; if (slv_if.d_ready !== 1'b1) begin failures++; $display("FAIL reset_in_d_ready got=%0b exp=1", slv_if.d_ready); end
    checks++; if (a_count !== 2'd0) begin failures++; $display("FAIL reset_a_count got=%0d exp=0", a_count); end
    checks++; if (d_count !== 2'd0) begin failures++; $display("FAIL reset_d_count got=%0d exp=0", d_count); end
    checks++; if (a_count3 !== 2'd0 || d_count3 !== 1'b0) begin failures++; $display("FAIL reset_dut3_counts got=%0d/%0d exp=0/0", a_count3, d_count3); end
  endtask

  task automatic test_fill_a();
    tl_a_t b;
    logic [AW-1:0] b1, b2;
    b = '0; b.opcode = OpPutFullData; b.mask = '1;
    b.address = 32'h1000; b.data = {$urandom, $urandom}; b1 = b;
    b.address = 32'h2000; b.data = {$urandom, $urandom}; b2 = b;
    @(negedge clock);
    slv_if.a_ready = 1'b0; mst_if.a_valid = 1'b1; mst_if.a_bits = b1;
    @(negedge clock);
    mst_if.a_bits = b2;
    @(negedge clock);
    mst_if.a_valid = 1'b0;
    #1;
    checks++; if (a_count !== 2'd2) begin failures++; $display("FAIL fill_a_count got=%0d exp=2", a_count); end
    checks++; if (mst_if.a_ready !== 1'b0) begin failures++; $display("FAIL fill_in_a_ready got=%0b exp=0", mst_if.a_ready); end
    slv_if.a_ready = 1'b1;
    #1;
    checks++; if (slv_if.a_valid !== 1'b1 || slv_if.a_bits !== b1) begin failures++; $display("FAIL fill_first_beat got=%0b/%0h exp=1/%0h", slv_if.a_valid, slv_if.a_bits, b1); end
    @(negedge clock);
    #1;
    checks++; if (slv_if.a_valid !== 1'b1 || slv_if.a_bits !== b2) begin failures++; $display("FAIL fill_second_beat got=%0b/%0h exp=1/%0h", slv_if.a_valid, slv_if.a_bits, b2); end
    checks++; if (a_count !== 2'd1) begin failures++; $display("FAIL fill_a_count_mid got=%0d exp=1", a_count); end
    @(negedge clock);
    #1;
    checks++; if (slv_if.a_valid !== 1'b0 || a_count !== 2'd0) begin failures++; $display("FAIL fill_drained got=%0b/%0d exp=0/0", slv_if.a_valid, a_count); end
    slv_if.a_ready = 1'b0;
  endtask

  task automatic test_stream_d();
    tl_d_t b, got;
    logic exp_v;
    logic [1:0] exp_c;
    logic [63:0] exp_data;
    mst_if.d_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clock);
      b = '0; b.opcode = OpAccessAckData; b.data = 64'(k);
      slv_if.d_valid = (k < 16); slv_if.d_bits = b;
      #1;
      exp_v    = FlowEn ? (k < 16) : (k >= 1 && k <= 16);
      exp_data = FlowEn ? 64'(k) : 64'(k - 1);
      exp_c    = (!FlowEn && k >= 1 && k <= 16) ? 2'd1 : 2'd0;
      got      = mst_if.d_bits;
      checks++; if (mst_if.d_valid !== exp_v) begin failures++; $display("FAIL stream_d_valid k=%0d got=%0b exp=%0b", k, mst_if.d_valid, exp_v); end
      checks++; if (exp_v && got.data !== exp_data) begin failures++; $display("FAIL stream_d_data k=%0d got=%0h exp=%0h", k, got.data, exp_data); end
      checks++; if (d_count !== exp_c) begin failures++; $display("FAIL stream_d_count k=%0d got=%0d exp=%0d", k, d_count, exp_c); end
      checks++; if (slv_if.d_ready !== 1'b1) begin failures++; $display("FAIL stream_in_d_ready k=%0d got=%0b exp=1", k, slv_if.d_ready); end
    end
    slv_if.d_valid = 1'b0;
    mst_if.d_ready = 1'b0;
  endtask

  task automatic test_simul_push_pop();
    logic [AW-1:0] b1, b2;
    b1 = rand_a(); b2 = rand_a();
    @(negedge clock);
    mst_if.a_valid = 1'b1; mst_if.a_bits = b1; slv_if.a_ready = 1'b0;
    @(negedge clock);
    mst_if.a_bits = b2; slv_if.a_ready = 1'b1;
    #1;
    checks++; if (slv_if.a_bits !== b1 || a_count !== 2'd1) begin failures++; $display("FAIL simul_head got=%0h/%0d exp=%0h/1", slv_if.a_bits, a_count, b1); end
    @(negedge clock);
    mst_if.a_valid = 1'b0; slv_if.a_ready = 1'b0;
    #1;
    checks++; if (a_count !== 2'd1) begin failures++; $display("FAIL simul_count got=%0d exp=1", a_count); end
    checks++; if (slv_if.a_valid !== 1'b1 || slv_if.a_bits !== b2) begin failures++; $display("FAIL simul_payload got=%0b/%0h exp=1/%0h", slv_if.a_valid, slv_if.a_bits, b2); end
    slv_if.a_ready = 1'b1;
    @(negedge clock);
    slv_if.a_ready = 1'b0;
    #1;
    checks++; if (a_count !== 2'd0) begin failures++; $display("FAIL simul_drain got=%0d exp=0", a_count); end
  endtask

  task automatic test_flow();
    logic [AW-1:0] b;
    b = rand_a();
    @(negedge clock);
    mst_if.a_valid = 1'b1; mst_if.a_bits = b; slv_if.a_ready = 1'b1;
    #1;
    checks++; if (slv_if.a_valid !== FlowEn) begin failures++; $display("FAIL flow_valid got=%0b exp=%0b", slv_if.a_valid, FlowEn); end
    checks++; if (slv_if.a_valid && slv_if.a_bits !== b) begin failures++; $display("FAIL flow_bits got=%0h exp=%0h", slv_if.a_bits, b); end
    checks++; if (a_count !== 2'd0) begin failures++; $display("FAIL flow_count_same got=%0d exp=0", a_count); end
    @(negedge clock);
    mst_if.a_valid = 1'b0; slv_if.a_ready = 1'b0;
    #1;
    checks++; if (a_count !== (FlowEn ? 2'd0 : 2'd1)) begin failures++; $display("FAIL flow_count_after got=%0d exp=%0d", a_count, FlowEn ? 0 : 1); end
    checks++; if (slv_if.a_valid !== !FlowEn) begin failures++; $display("FAIL flow_valid_after got=%0b exp=%0b", slv_if.a_valid, !FlowEn); end
    slv_if.a_ready = 1'b1;
    @(negedge clock);
    slv_if.a_ready = 1'b0;
  endtask

  // Random traffic on the depth-3 A and depth-1 D channels against queue models.
  task automatic test_random_wrap();
    logic [AW-1:0] qa[$];
    logic [DW-1:0] qd[$];
    logic ev, er, push, pop;
    logic [AW-1:0] eba;
    logic [DW-1:0] ebd;
    int pushes_a = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clock);
      mst3_if.a_valid = 1'($urandom_range(0, 1)); mst3_if.a_bits = rand_a();
      slv3_if.a_ready = 1'($urandom_range(0, 1));
      slv3_if.d_valid = 1'($urandom_range(0, 1)); slv3_if.d_bits = rand_d();
      mst3_if.d_ready = 1'($urandom_range(0, 1));
      #1;
      er  = (qa.size() < 3) || (FlowEn && slv3_if.a_ready);
      ev  = (qa.size() != 0) || (FlowEn && mst3_if.a_valid);
      eba = (qa.size() != 0) ? qa[0] : mst3_if.a_bits;
      checks++; if (mst3_if.a_ready !== er) begin failures++; $display("FAIL rand_a_ready cyc=%0d got=%0b exp=%0b", cyc, mst3_if.a_ready, er); end
      checks++; if (slv3_if.a_valid !== ev) begin failures++; $display("FAIL rand_a_valid cyc=%0d got=%0b exp=%0b", cyc, slv3_if.a_valid, ev); end
      checks++; if (ev && slv3_if.a_bits !== eba) begin failures++; $display("FAIL rand_a_bits cyc=%0d got=%0h exp=%0h", cyc, slv3_if.a_bits, eba); end
      checks++; if (a_count3 !== 2'(qa.size())) begin failures++; $display("FAIL rand_a_count cyc=%0d got=%0d exp=%0d", cyc, a_count3, qa.size()); end
      push = mst3_if.a_valid && er;
      pop  = ev && slv3_if.a_ready;
      if (push) begin qa.push_back(mst3_if.a_bits); pushes_a++; end
      if (pop) void'(qa.pop_front());

      er  = (qd.size() < 1) || (FlowEn && mst3_if.d_ready);
      ev  = (qd.size() != 0) || (FlowEn && slv3_if.d_valid);
      ebd = (qd.size() != 0) ? qd[0] : slv3_if.d_bits;
      checks++; if (slv3_if.d_ready !== er) begin failures++; $display("FAIL rand_d_ready cyc=%0d got=%0b exp=%0b", cyc, slv3_if.d_ready, er); end
      checks++; if (mst3_if.d_valid !== ev) begin failures++; $display("FAIL rand_d_valid cyc=%0d got=%0b exp=%0b", cyc, mst3_if.d_valid, ev); end
      checks++; if (ev && mst3_if.d_bits !== ebd) begin failures++; $display("FAIL rand_d_bits cyc=%0d got=%0h exp=%0h", cyc, mst3_if.d_bits, ebd); end
      checks++; if (d_count3 !== 1'(qd.size())) begin failures++; $display("FAIL rand_d_count cyc=%0d got=%0d exp=%0d", cyc, d_count3, qd.size()); end
      push = slv3_if.d_valid && er;
      pop  = ev && mst3_if.d_ready;
      if (push) qd.push_back(slv3_if.d_bits);
      if (pop) void'(qd.pop_front());
    end
    checks++; if (pushes_a < 10) begin failures++; $display("FAIL rand_a_pushes got=%0d exp>=10", pushes_a); end
    @(negedge clock);
    mst3_if.a_valid = 1'b0; slv3_if.a_ready = 1'b0; slv3_if.d_valid = 1'b0; mst3_if.d_ready = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clock);
    slv_if.a_ready = 1'b0; mst_if.a_valid = 1'b1; mst_if.a_bits = rand_a();
    @(negedge clock);
    mst_if.a_bits = rand_a();
    @(negedge clock);
    mst_if.a_valid = 1'b0;
    #1;
    checks++; if (a_count !== 2'd2) begin failures++; $display("FAIL midrst_pre_count got=%0d exp=2", a_count); end
    reset_n = 1'b0;
    #1;
    checks++; if (a_count !== 2'd0) begin failures++; $display("FAIL midrst_async_count got=%0d exp=0", a_count); end
    checks++; if (slv_if.a_valid !== 1'b0) begin failures++; $display("FAIL midrst_async_valid got=%0b exp=0", slv_if.a_valid); end
    checks++; if (mst_if.a_ready !== 1'b1) begin failures++; $display("FAIL midrst_async_ready got=%0b exp=1", mst_if.a_ready); end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    checks++; if (a_count !== 2'd0 || slv_if.a_valid !== 1'b0) begin failures++; $display("FAIL midrst_after got=%0d/%0b exp=0/0", a_count, slv_if.a_valid); end
  endtask

  initial begin
    mst_if.a_valid = 1'b0; mst_if.a_bits = '0; mst_if.d_ready = 1'b0;
    slv_if.a_ready = 1'b0; slv_if.d_valid = 1'b0; slv_if.d_bits = '0;
    mst3_if.a_valid = 1'b0; mst3_if.a_bits = '0; mst3_if.d_ready = 1'b0;
    slv3_if.a_ready = 1'b0; slv3_if.d_valid = 1'b0; slv3_if.d_bits = '0;
    test_reset();
    test_fill_a();
    test_stream_d();
    test_simul_push_pop();
    test_flow();
    test_random_wrap();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tl_channel_buffer.md
# tl_channel_buffer

- Parametrised two-channel TileLink-UL buffer: one FIFO on the A (request) channel, one on the D (response) channel.
- Sits between a master-side port and a slave-side port and replaces the current zero-state pass-through wiring between the two.
- Adds configurable depth per channel, a configurable bus shape, occupancy reporting and an optional flow-through path.
- The two channels are independent; there is no ordering or coupling logic between A and D.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, data width; power of 2, ≥8; mask width = DATA_W/8
- SIZE_W, 3, size field width
- SRC_W, 3, source ID width
- SINK_W, 1, sink ID width
- A_DEPTH, 2, A FIFO entries; ≥1
- D_DEPTH, 2, D FIFO entries; ≥1

Ports:
- clock  in  1  sole clock; rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_a_valid / in_a_ready  in / out  1  master-side A handshake
- in_a_bits  in  A_W  packed A beat: opcode 3, param 3, size, source, address, mask, data, corrupt 1
- out_a_valid / out_a_ready  out / in  1  slave-side A handshake
- out_a_bits  out  A_W  A beat towards the slave
- in_d_valid / in_d_ready  in / out  1  slave-side D handshake
- in_d_bits  in  D_W  packed D beat: opcode 3, param 2, size, source, sink, denied 1, data, corrupt 1
- out_d_valid / out_d_ready  out / in  1  master-side D handshake
- out_d_bits  out  D_W  D beat towards the master
- a_count  out  $clog2(A_DEPTH+1)  A FIFO occupancy
- d_count  out  $clog2(D_DEPTH+1)  D FIFO occupancy

## Operation
Each channel is the same FIFO, parametrised by payload width and depth.

Handshake:
- A beat transfers when valid && ready are both high on a rising clock edge.
- Outputs of this block obey the rule that valid never depends on ready.
- in_*_ready = (count < DEPTH); this is registered-path only, with no combinational dependence on out_*_ready.
- out_*_valid = (count != 0).
- out_*_bits = entry at the read pointer. Payload is passed untouched; there is no field interpretation.

Pointers and count:
- Read and write pointers are $clog2(DEPTH) bits wide, or 1 bit when DEPTH=1.
- Each pointer wraps from DEPTH-1 to 0; DEPTH need not be a power of 2.
- count increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.

Boundaries:
- Full with a simultaneous pop: no push is possible because ready is low; count decrements.
- Empty with a push: the entry is written and count becomes 1; out valid rises next cycle (see Configuration).
- Push and pop in the same cycle, count ≥1: both pointers advance; the FIFO order is preserved.

Reset:
- Both pointers and both counts go to 0, so out_*_valid=0 and in_*_ready=1.
- Storage is not reset; out_*_bits are don't-care while valid=0.
- Reset asserted mid-burst discards all buffered beats immediately, asynchronously.
- Deassertion takes effect on the first clock edge after reset_n rises.

## Timing
- Latency is 1 cycle from an in-side push to out valid, when empty.
- Throughput is 1 beat/cycle per channel with no bubbles when DEPTH≥2.
- When DEPTH=1, throughput is 1 beat per 2 cycles unless flow-through is enabled.
- in_ready and count update on the clock edge after a push or pop.

## Configuration
TL_CHANNEL_BUFFER_FLOW_EN.

Defined (flow-through):
- When count==0 and in_valid=1, out_valid=1 and out_bits=in_bits combinationally, in the same cycle.
- If out_ready is also high, the beat bypasses storage and count stays 0.
- in_ready = (count<DEPTH) || out_ready, so a full FIFO accepts a push in the same cycle as a pop.

Undefined:
- Minimum latency is 1 cycle.
- No combinational path exists between the in side and the out side of a channel.

## Structure
- Shared package tl_buffer_pkg holds:
  - field width constants;
  - A_W / D_W functions of the parameters;
  - packed A/D beat struct typedefs and field order (opcode in the MSBs, corrupt in the LSB);
  - TileLink opcode localparams, used by benches only.
- One sub-module: tl_buffer_fifo (WIDTH, DEPTH), instantiated once per channel.

## Test plan
- Reset: hold reset_n=0 for 3 cycles, then release → out_a_valid=0, out_d_valid=0, in_a_ready=1, a_count=0, d_count=0.
- Fill A (A_DEPTH=2, out_a_ready=0): push beats address 0x1000 and 0x2000 → a_count=2 and in_a_ready=0. Then raise out_a_ready → 0x1000 then 0x2000 delivered on consecutive cycles, in order.
- Streaming D (D_DEPTH=2): 16 back-to-back beats with data 0..15 and out_d_ready=1 → 16 beats out in order, no stall after the first, d_count ≤1 throughout.
- Wrap (A_DEPTH=3): 10 pushes with random out_a_ready → order preserved across every pointer wrap, and a_count always equals pushes minus pops.
- Simultaneous push and pop at count=1 → count stays 1 and the payload is correct. Reset_n pulsed low mid-burst with count=2 → count=0 and out_valid=0 immediately, with no clock edge needed.
- FLOW_EN defined, empty FIFO, in_a_valid and out_a_ready both high → out_a_bits equals in_a_bits in the same cycle and a_count stays 0.
